// File: rtl/output_weight_update_if.sv
// Handshake/data bundle between the output-layer weight updater and its driver.
// Carries the weight load path, pass start, error inputs and the weight/status outputs.
interface output_weight_update_if;
    logic        load_i;
    logic [63:0] w_flat_i;
    logic        start_i;
    logic [22:0] final_i;
    logic [3:0]  init_i;
    logic [79:0] x_flat_i;
    logic [63:0] w_flat_o;
    logic [7:0]  w_we_o;
    logic        busy_o;
    logic        done_o;
    logic        err_zero_o;

    modport slave (
        input  load_i, w_flat_i, start_i, final_i, init_i, x_flat_i,
        output w_flat_o, w_we_o, busy_o, done_o, err_zero_o
    );

    modport master (
        output load_i, w_flat_i, start_i, final_i, init_i, x_flat_i,
        input  w_flat_o, w_we_o, busy_o, done_o, err_zero_o
    );
endinterface

// File: rtl/output_weight_update.sv
// Gradient-descent update of the 8 output-layer weights, one weight per cycle.
// Pass takes 10 cycles start-to-idle (2 if err == 0); all inputs are ignored while busy.
module output_weight_update #(
    parameter int LR_SHIFT = 4,
    parameter int NW       = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output_weight_update_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

    localparam logic [2:0] LAST_IDX = 3'(NW - 1);

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic signed [23:0]     err_q, err_d;
    logic [NW-1:0][9:0]     x_q, x_d;
    logic [NW-1:0][7:0]     w_q, w_d;
    logic [7:0]             we_q, we_d;
    logic                   err_zero_q, err_zero_d;

    logic [23:0]            err_start;
    logic signed [34:0]     grad;
    logic signed [34:0]     delta;
    logic signed [35:0]     nw;
    logic [7:0]             w_upd;

    assign err_start = {1'b0, bus.final_i} - {20'd0, bus.init_i};

    // Datapath for the weight currently addressed by idx_q.
    always_comb begin
        grad  = $signed({{11{err_q[23]}}, err_q}) * $signed({25'd0, x_q[idx_q]});
        delta = grad >>> LR_SHIFT;
        nw    = $signed({28'd0, w_q[idx_q]}) - $signed({delta[34], delta});
        if (nw[35]) begin
            w_upd = 8'd0;
        end else if (|nw[34:8]) begin
            w_upd = 8'hFF;
        end else begin
            w_upd = nw[7:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_d      = err_q;
        x_d        = x_q;
        w_d        = w_q;
        we_d       = '0;
        err_zero_d = err_zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load_i) begin
                    w_d = bus.w_flat_i;
                end else if (bus.start_i) begin
                    err_d      = err_start;
                    x_d        = bus.x_flat_i;
                    idx_d      = 3'd0;
                    err_zero_d = (err_start == 24'd0);
                    state_d    = (err_start == 24'd0) ? S_DONE : S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_d[idx_q]  = w_upd;
                we_d[idx_q] = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            err_q      <= '0;
            x_q        <= '0;
            w_q        <= '0;
            we_q       <= '0;
            err_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            x_q        <= x_d;
            w_q        <= w_d;
            we_q       <= we_d;
            err_zero_q <= err_zero_d;
        end
    end

    assign bus.w_flat_o   = w_q;
    assign bus.w_we_o     = we_q;
    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.done_o     = (state_q == S_DONE);
    assign bus.err_zero_o = err_zero_q;
endmodule

// File: tb/tb_output_weight_update.sv
// Directed bench for output_weight_update: whole-pass reference model plus per-cycle compare.
module tb_output_weight_update;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    output_weight_update_if bus();

    output_weight_update #(.LR_SHIFT(4), .NW(8)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: final weights are computed at the start edge; m_t is k for cycle N+k.
    int m_w [8];
    int m_new [8];
    bit m_active, m_zero, m_errz;
    int m_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        longint err, g, d, nwv;
        m_active = 1'b0; m_zero = 1'b0; m_errz = 1'b0; m_t = 0;
        foreach (m_w[k]) begin m_w[k] = 0; m_new[k] = 0; end
        forever begin
            @(posedge clk_i or negedge rst_i);
            if (!rst_i) begin
                m_active = 1'b0; m_zero = 1'b0; m_errz = 1'b0; m_t = 0;
                foreach (m_w[k]) begin m_w[k] = 0; m_new[k] = 0; end
            end else if (m_active) begin
                m_t++;
                if (m_t == (m_zero ? 2 : 10)) begin
                    m_active = 1'b0;
                    m_w = m_new;
                end
            end else if (bus.load_i) begin
                for (int k = 0; k < 8; k++) m_w[k] = int'(bus.w_flat_i[8*k +: 8]);
            end else if (bus.start_i) begin
                err = longint'(bus.final_i) - longint'(bus.init_i);
                for (int k = 0; k < 8; k++) begin
                    g   = err * longint'(bus.x_flat_i[10*k +: 10]);
                    d   = g >>> 4;
                    nwv = longint'(m_w[k]) - d;
                    m_new[k] = (nwv < 0) ? 0 : (nwv > 255) ? 255 : int'(nwv);
                end
                m_zero   = (err == 0);
                m_errz   = m_zero;
                m_active = 1'b1;
                m_t      = 1;
            end
        end
    end

    initial begin
        logic [63:0] ew;
        logic [7:0]  ewe;
        forever begin
            @(negedge clk_i);
            if (chk_en) begin
                for (int k = 0; k < 8; k++)
                    ew[8*k +: 8] = (m_active && m_t >= k + 2) ? 8'(m_new[k]) : 8'(m_w[k]);
                ewe = (m_active && !m_zero && m_t >= 2) ? 8'(1 << (m_t - 2)) : 8'd0;
                chk("w_flat_o", bus.w_flat_o, ew);
                chk("w_we_o", bus.w_we_o, ewe);
                chk("busy_o", bus.busy_o, m_active);
                chk("done_o", bus.done_o, m_active && (m_t == (m_zero ? 1 : 9)));
                chk("err_zero_o", bus.err_zero_o, m_errz);
            end
        end
    end

    task automatic do_load(input logic [63:0] w, input bit with_start);
        @(negedge clk_i);
        bus.w_flat_i = w;
        bus.load_i   = 1'b1;
        bus.start_i  = with_start;
        bus.final_i  = 23'd50;
        bus.init_i   = 4'd1;
        @(posedge clk_i);
        #1;
        bus.load_i  = 1'b0;
        bus.start_i = 1'b0;
    endtask

    // mode 0: plain pass, 1: poke start/load while busy, 2: reset during UPDATE idx 3
    task automatic run_pass(input logic [22:0] fin, input logic [3:0] tgt, input logic [79:0] x,
                            input int mode, output int done_at, output int done_cnt, output int we_cnt);
        done_at = 0; done_cnt = 0; we_cnt = 0;
        @(negedge clk_i);
        bus.final_i  = fin;
        bus.init_i   = tgt;
        bus.x_flat_i = x;
        bus.start_i  = 1'b1;
        @(posedge clk_i);
        #1;
        bus.start_i  = 1'b0;
        bus.final_i  = 23'h7FFFFF;
        bus.init_i   = 4'd0;
        bus.x_flat_i = '1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk_i);
            if (bus.done_o) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (bus.w_we_o != 8'd0) we_cnt++;
            if (mode == 1 && k == 3) begin
                bus.start_i  = 1'b1;
                bus.load_i   = 1'b1;
                bus.w_flat_i = '0;
            end
            if (mode == 1 && k == 4) begin
                bus.start_i = 1'b0;
                bus.load_i  = 1'b0;
            end
            if (mode == 2 && k == 4) begin
                #2 rst_i = 1'b0;
                #1;
                chk("rst_async_w", bus.w_flat_o, 64'd0);
                chk("rst_async_busy", bus.busy_o, 1'b0);
                chk("rst_async_we", bus.w_we_o, 8'd0);
                chk("rst_async_done", bus.done_o, 1'b0);
            end
        end
        if (mode == 2) begin
            @(negedge clk_i);
            #2 rst_i = 1'b1;
        end
    endtask

    initial begin
        int da, dc, wc;
        bus.load_i = 1'b0; bus.start_i = 1'b0; bus.w_flat_i = '0;
        bus.final_i = '0; bus.init_i = '0; bus.x_flat_i = '0;
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        chk_en = 1'b1;
        @(negedge clk_i);
        chk("reset_w", bus.w_flat_o, 64'd0);
        chk("reset_busy", bus.busy_o, 1'b0);
        chk("reset_done", bus.done_o, 1'b0);
        chk("reset_errz", bus.err_zero_o, 1'b0);
        #2 rst_i = 1'b1;

        do_load({8{8'd100}}, 1'b0);
        @(negedge clk_i);
        chk("load_w", bus.w_flat_o, {8{8'd100}});

        run_pass(23'd20, 4'd4, {70'd0, 10'd16}, 0, da, dc, wc);
        chk("t1_done_at", da, 9);
        chk("t1_done_cnt", dc, 1);
        chk("t1_we_cnt", wc, 8);
        chk("t1_w", bus.w_flat_o, {{7{8'd100}}, 8'd84});

        do_load({{7{8'd100}}, 8'd5}, 1'b0);
        run_pass(23'd20, 4'd4, {70'd0, 10'd16}, 0, da, dc, wc);
        chk("lo_sat_w0", bus.w_flat_o[7:0], 8'd0);

        do_load({{7{8'd100}}, 8'd240}, 1'b0);
        run_pass(23'd0, 4'd15, {70'd0, 10'd32}, 0, da, dc, wc);
        chk("hi_sat_w0", bus.w_flat_o[7:0], 8'd255);

        do_load({8{8'd100}}, 1'b0);
        run_pass(23'd4, 4'd12, {40'd0, 10'd7, 10'd3, 10'd100, 10'd0}, 0, da, dc, wc);
        chk("neg_err_w", bus.w_flat_o, {{4{8'd100}}, 8'd104, 8'd102, 8'd150, 8'd100});

        run_pass(23'd9, 4'd9, {8{10'd1}}, 0, da, dc, wc);
        chk("zero_done_at", da, 1);
        chk("zero_we_cnt", wc, 0);
        chk("zero_errz", bus.err_zero_o, 1'b1);
        chk("zero_w", bus.w_flat_o, {{4{8'd100}}, 8'd104, 8'd102, 8'd150, 8'd100});

        run_pass(23'd20, 4'd4, {70'd0, 10'd16}, 1, da, dc, wc);
        chk("busy_poke_done_cnt", dc, 1);
        chk("busy_poke_w", bus.w_flat_o, {{4{8'd100}}, 8'd104, 8'd102, 8'd150, 8'd84});

        do_load({8{8'd77}}, 1'b1);
        @(negedge clk_i);
        chk("load_start_busy", bus.busy_o, 1'b0);
        chk("load_start_w", bus.w_flat_o, {8{8'd77}});
        repeat (3) @(negedge clk_i);

        run_pass(23'd20, 4'd4, {8{10'd16}}, 2, da, dc, wc);
        chk("rst_mid_done_cnt", dc, 0);
        chk("rst_mid_w", bus.w_flat_o, 64'd0);
        repeat (2) @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
